// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one data-FIFO write port among NUM_REQ
//   requesters. A requester that wins with a non-last beat locks the port
//   (BURST) until its req_last beat is accepted.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req_valid/last    per-requester beat valid / last-of-burst
//   req_data          requester i at [i*DATA_W +: DATA_W]
//   req_ready         per-requester accept, combinational, one-hot or zero
//   fifo_afull        FIFO has at most one free entry; stalls all requesters
//   fifo_wr_en/data   registered write strobe/data, one cycle after accept
//   grant_id          current or most recent owner
//   busy              high while a burst holds the port
//   grant_cnt         (ARB_STATS_EN only) 16-bit saturating completed-burst
//                     counter per requester, requester i at [i*16 +: 16]
//
// Build option: define ARB_STATS_EN to add grant_cnt and its counters.

`ifdef ARB_STATS_EN
module fifo_wr_arbiter_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule
`endif

module fifo_wr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_afull,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [ID_W-1:0]           grant_id,
`ifdef ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]     grant_cnt,
`endif
  output logic                      busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                           state_q, state_d;
  logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]                  grant_id_q, grant_id_d;
  logic                             fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_W-1:0]                fifo_wr_data_q, fifo_wr_data_d;

  logic [NUM_REQ-1:0][DATA_W-1:0]   data_arr;
  logic [ID_W-1:0]                  winner;
  logic                             win_vld;
  logic [ID_W:0]                    scan_idx;
  logic [ID_W-1:0]                  sel;
  logic                             sel_last;
  logic                             accept;

  assign data_arr = req_data;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
    return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + ID_W'(1);
  endfunction

  // Round-robin scan starting at rr_ptr; the extra index bit lets the sum
  // wrap correctly when NUM_REQ is not a power of two.
  always_comb begin
    winner   = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      if (!win_vld && req_valid[scan_idx[ID_W-1:0]]) begin
        winner  = scan_idx[ID_W-1:0];
        win_vld = 1'b1;
      end
    end
  end

  // Reset gates ready directly: state is already IDLE during reset but the
  // scan would still pick a winner from live req_valid.
  always_comb begin
    req_ready = '0;
    if (!reset && !fifo_afull) begin
      if (state_q == IDLE) begin
        if (win_vld) req_ready[winner] = 1'b1;
      end else begin
        req_ready[grant_id_q] = 1'b1;
      end
    end
  end

  assign sel      = (state_q == IDLE) ? winner : grant_id_q;
  assign sel_last = req_last[sel];
  assign accept   = |(req_valid & req_ready);

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    fifo_wr_en_d   = accept;
    fifo_wr_data_d = fifo_wr_data_q;
    if (accept) begin
      fifo_wr_data_d = data_arr[sel];
      unique case (state_q)
        IDLE: begin
          grant_id_d = winner;
          if (sel_last) rr_ptr_d = wrap_inc(winner);
          else          state_d  = BURST;
        end
        BURST: begin
          // Owner dropping valid mid-burst simply stalls here; no timeout.
          if (sel_last) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(grant_id_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
    end
  end

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign grant_id     = grant_id_q;
  assign busy         = (state_q == BURST);

`ifdef ARB_STATS_EN
  logic [NUM_REQ-1:0]       burst_done;
  logic [NUM_REQ-1:0][15:0] cnt_arr;

  always_comb begin
    burst_done = '0;
    if (accept && sel_last) burst_done[sel] = 1'b1;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    fifo_wr_arbiter_sat_cnt u_cnt (
      .clk (clk),
      .rst (reset),
      .inc (burst_done[i]),
      .cnt (cnt_arr[i])
    );
  end

  assign grant_cnt = cnt_arr;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the arbitration
// rules (owner index, round-robin start, last write).
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_afull;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_afull   (fifo_afull),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
`ifdef ARB_STATS_EN
    .grant_cnt    (grant_cnt),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: -1 owner means no burst in progress.
  int            m_owner, m_rr, m_gid;
  logic          m_wr_en;
  logic [DW-1:0] m_wr_data;
  int            m_cnt [N];
  logic [N-1:0]  exp_ready, obs_ready;

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r = '0;
    if (reset || fifo_afull) return r;
    if (m_owner >= 0) begin
      r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++)
      if (req_valid[(m_rr + k) % N]) begin
        r[(m_rr + k) % N] = 1'b1;
        return r;
      end
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_gid = 0; m_wr_en = 1'b0; m_wr_data = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic bump(input int i);
    if (m_cnt[i] < 65535) m_cnt[i]++;
  endtask

  task automatic model_edge();
    logic [N-1:0] acc;
    int i;
    acc = req_valid & exp_ready;
    m_wr_en = (acc != '0);
    if (acc != '0) begin
      i = 0;
      for (int k = 0; k < N; k++) if (acc[k]) i = k;
      m_wr_data = req_data[i*DW +: DW];
      if (m_owner < 0) begin
        m_gid = i;
        if (req_last[i]) begin m_rr = (i + 1) % N; bump(i); end
        else m_owner = i;
      end else if (req_last[i]) begin
        m_owner = -1;
        m_rr    = (m_gid + 1) % N;
        bump(i);
      end
    end
  endtask

  // One clock: inputs already driven; ready sampled at negedge, registered
  // outputs available on return (posedge + 1).
  task automatic tick();
    exp_ready = model_ready();
    @(negedge clk);
    obs_ready = req_ready;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; req_last = '0; req_data = '0; fifo_afull = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fifo_afull = 1'b0;
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'h11223344;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_chk++; if (req_ready !== 4'h0) $display("FAIL reset_ready got %b want 0000", req_ready); else n_pass++;
    n_chk++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); else n_pass++;
    n_chk++; if (fifo_wr_data !== 8'h00) $display("FAIL reset_wr_data got %h want 00", fifo_wr_data); else n_pass++;
    n_chk++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id got %0d want 0", grant_id); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    do_reset();
  endtask

  task automatic test_single();
    logic [7:0] beats [3] = '{8'hAA, 8'hBB, 8'hCC};
    do_reset();
    for (int b = 0; b < 3; b++) begin
      req_valid = 4'b0100;
      req_last  = (b == 2) ? 4'b0100 : 4'b0000;
      req_data  = '0;
      req_data[2*DW +: DW] = beats[b];
      tick();
      n_chk++; if (obs_ready !== 4'b0100) $display("FAIL single_ready beat%0d got %b want 0100", b, obs_ready); else n_pass++;
      n_chk++; if (fifo_wr_en !== 1'b1) $display("FAIL single_wr_en beat%0d got %b want 1", b, fifo_wr_en); else n_pass++;
      n_chk++; if (fifo_wr_data !== beats[b]) $display("FAIL single_data beat%0d got %h want %h", b, fifo_wr_data, beats[b]); else n_pass++;
      n_chk++; if (grant_id !== 2'd2) $display("FAIL single_grant beat%0d got %0d want 2", b, grant_id); else n_pass++;
      n_chk++; if (busy !== (b < 2)) $display("FAIL single_busy beat%0d got %b want %b", b, busy, b < 2); else n_pass++;
    end
    req_valid = '0; req_last = '0;
    tick();
    n_chk++; if (fifo_wr_en !== 1'b0) $display("FAIL single_idle_wr_en got %b want 0", fifo_wr_en); else n_pass++;
    n_chk++; if (fifo_wr_data !== 8'hCC) $display("FAIL single_hold_data got %h want cc", fifo_wr_data); else n_pass++;
  endtask

  task automatic test_fairness();
    int e;
    do_reset();
    req_valid = 4'hF; req_last = 4'hF;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'h10 + 8'(i);
    for (int c = 0; c < 5; c++) begin
      e = c % N;
      tick();
      n_chk++; if (obs_ready !== 4'(1 << e)) $display("FAIL fair_ready c%0d got %b want %b", c, obs_ready, 4'(1 << e)); else n_pass++;
      n_chk++; if (grant_id !== 2'(e)) $display("FAIL fair_grant c%0d got %0d want %0d", c, grant_id, e); else n_pass++;
      n_chk++; if (fifo_wr_data !== 8'h10 + 8'(e)) $display("FAIL fair_data c%0d got %h want %h", c, fifo_wr_data, 8'h10 + 8'(e)); else n_pass++;
    end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_burst_lock();
    do_reset();
    req_valid = 4'b0010; req_last = '0; req_data = '0;
    req_data[1*DW +: DW] = 8'h21;
    tick();
    n_chk++; if (busy !== 1'b1) $display("FAIL lock_busy got %b want 1", busy); else n_pass++;
    req_valid = 4'b1011; req_last = 4'b1001;
    req_data[0 +: DW] = 8'h01; req_data[3*DW +: DW] = 8'h31;
    for (int b = 0; b < 4; b++) begin
      req_data[1*DW +: DW] = 8'h22 + 8'(b);
      if (b == 3) req_last[1] = 1'b1;
      tick();
      n_chk++; if (obs_ready !== 4'b0010) $display("FAIL lock_ready b%0d got %b want 0010", b, obs_ready); else n_pass++;
    end
    n_chk++; if (busy !== 1'b0) $display("FAIL lock_release_busy got %b want 0", busy); else n_pass++;
    req_valid = 4'b1001;
    tick();
    n_chk++; if (obs_ready !== 4'b1000) $display("FAIL lock_next_ready got %b want 1000", obs_ready); else n_pass++;
    n_chk++; if (grant_id !== 2'd3) $display("FAIL lock_next_grant got %0d want 3", grant_id); else n_pass++;
    tick();
    n_chk++; if (obs_ready !== 4'b0001) $display("FAIL lock_wrap_ready got %b want 0001", obs_ready); else n_pass++;
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_backpressure();
    logic [7:0] got [$];
    int b = 0;
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      fifo_afull = (cyc >= 3 && cyc < 8);
      req_valid  = {3'b000, b < 10};
      req_last   = {3'b000, b == 9};
      req_data   = '0;
      req_data[0 +: DW] = 8'h40 + 8'(b);
      tick();
      if (fifo_wr_en) got.push_back(fifo_wr_data);
      if (fifo_afull) begin
        n_chk++; if (obs_ready !== 4'b0) $display("FAIL bp_ready c%0d got %b want 0000", cyc, obs_ready); else n_pass++;
        n_chk++; if (fifo_wr_en !== 1'b0) $display("FAIL bp_wr_en c%0d got %b want 0", cyc, fifo_wr_en); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL bp_busy c%0d got %b want 1", cyc, busy); else n_pass++;
      end
      if (req_valid[0] && obs_ready[0]) b++;
    end
    fifo_afull = 1'b0; req_valid = '0; req_last = '0;
    n_chk++; if (got.size() !== 10) $display("FAIL bp_count got %0d want 10", got.size()); else n_pass++;
    for (int k = 0; k < got.size() && k < 10; k++) begin
      n_chk++; if (got[k] !== 8'h40 + 8'(k)) $display("FAIL bp_beat%0d got %h want %h", k, got[k], 8'h40 + 8'(k)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b0010; req_last = '0; req_data = '0;
    req_data[1*DW +: DW] = 8'h5A;
    tick();
    req_data[1*DW +: DW] = 8'h5B;
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_chk++; if (fifo_wr_en !== 1'b0) $display("FAIL rst_mid_wr_en got %b want 0", fifo_wr_en); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (grant_id !== 2'd0) $display("FAIL rst_mid_grant got %0d want 0", grant_id); else n_pass++;
    n_chk++; if (req_ready !== 4'b0) $display("FAIL rst_mid_ready got %b want 0000", req_ready); else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_random();
    int n_err = 0;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      fifo_afull = ($urandom_range(0, 99) < 15);
      tick();
      if (obs_ready !== exp_ready || fifo_wr_en !== m_wr_en || fifo_wr_data !== m_wr_data ||
          grant_id !== 2'(m_gid) || busy !== (m_owner >= 0)) begin
        if (n_err < 10)
          $display("FAIL rand c%0d ready %b/%b wr_en %b/%b data %h/%h grant %0d/%0d busy %b/%b (got/want)",
                   cyc, obs_ready, exp_ready, fifo_wr_en, m_wr_en, fifo_wr_data, m_wr_data,
                   grant_id, m_gid, busy, m_owner >= 0);
        n_err++;
      end else n_pass++;
      n_chk++;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && exp_ready[i])
          req_valid[i] = ($urandom_range(0, 99) < 60);
        else if (!req_valid[i])
          req_valid[i] = ($urandom_range(0, 99) < 30);
        else
          continue;
        req_last[i] = ($urandom_range(0, 99) < 40);
        req_data[i*DW +: DW] = 8'($urandom);
      end
    end
    req_valid = '0; req_last = '0; fifo_afull = 1'b0;
`ifdef ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      n_chk++; if (grant_cnt[i*16 +: 16] !== 16'(m_cnt[i])) $display("FAIL rand_cnt%0d got %0d want %0d", i, grant_cnt[i*16 +: 16], m_cnt[i]); else n_pass++;
    end
`endif
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_0077;
    repeat (70000) begin
      @(posedge clk);
    end
    #1 req_valid = '0;
    @(posedge clk); #1;
    n_chk++; if (grant_cnt[15:0] !== 16'hFFFF) $display("FAIL stats_sat got %h want ffff", grant_cnt[15:0]); else n_pass++;
    for (int i = 1; i < N; i++) begin
      n_chk++; if (grant_cnt[i*16 +: 16] !== 16'h0) $display("FAIL stats_other%0d got %h want 0000", i, grant_cnt[i*16 +: 16]); else n_pass++;
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_afull = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_burst_lock();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
